i3c_tb_unpack: RTL and testbench

I3C_TB_UNPACK -- requirements
Module: i3c_tb_unpack

---
 rtl/i3c_tb_unpack.sv | 99 +++++++++
 tb/tb_i3c_tb_unpack.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i3c_tb_unpack.sv
// Unpacks 1..4-byte writes into a byte stream for the downstream transmit buffer.
// Includes overflow reporting and a flush path that discards any bytes still held.
module i3c_tb_unpack #(
  parameter int unsigned ENA_WORD = 1,
  parameter int unsigned BIG_END  = 0
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  input  logic [1:0]  wr_bytes,
  input  logic        wr_end,
  output logic        wr_ready,
  input  logic        flush,
  output logic        tb_flush,
  output logic [2:0]  pend_cnt,
  output logic        avail_tb_ready,
  output logic [7:0]  avail_tb_data,
  output logic        avail_tb_end,
  input  logic        avail_tb_ack,
  output logic        set_wr_ovf,
  output logic        wr_ovf,
  input  logic        clear_wr_ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] hold_q;
  logic [1:0]  rem_q;
  logic [1:0]  idx_q;
  logic        hend_q;
  logic        tb_flush_q;
  logic        set_ovf_q;
  logic        ovf_q;

  logic [1:0]  eff_bytes;
  logic        last_ack;
  logic        load;
  logic        drop;

  always_comb begin
    eff_bytes = (ENA_WORD != 0) ? wr_bytes : 2'd0;
    last_ack  = (state_q == DRAIN) && (rem_q == '0) && avail_tb_ack;
    wr_ready  = ((state_q == IDLE) || last_ack) && !flush;
    load      = wr_valid && wr_ready;
    // A write that collides with a flush is discarded silently, not counted as overflow.
    drop      = wr_valid && !wr_ready && !flush;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      hend_q     <= 1'b0;
      tb_flush_q <= 1'b0;
      set_ovf_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      tb_flush_q <= flush;
      set_ovf_q  <= drop;
      ovf_q      <= drop | (ovf_q & ~clear_wr_ovf);
      if (flush) begin
        state_q <= IDLE;
        rem_q   <= '0;
        hend_q  <= 1'b0;
      end else if (load) begin
        state_q <= DRAIN;
        hold_q  <= wr_data;
        rem_q   <= eff_bytes;
        hend_q  <= wr_end;
        idx_q   <= (BIG_END != 0) ? eff_bytes : 2'd0;
      end else if ((state_q == DRAIN) && avail_tb_ack) begin
        if (rem_q == '0) begin
          state_q <= IDLE;
        end else begin
          rem_q <= rem_q - 2'd1;
          idx_q <= (BIG_END != 0) ? (idx_q - 2'd1) : (idx_q + 2'd1);
        end
      end
    end
  end

  always_comb begin
    avail_tb_ready = (state_q == DRAIN);
    avail_tb_data  = hold_q[{idx_q, 3'b000} +: 8];
    avail_tb_end   = hend_q && (rem_q == '0);
    pend_cnt       = (state_q == DRAIN) ? ({1'b0, rem_q} + 3'd1) : 3'd0;
    tb_flush       = tb_flush_q;
    set_wr_ovf     = set_ovf_q;
    wr_ovf         = ovf_q;
  end

endmodule

// File: tb/tb_i3c_tb_unpack.sv
// Self-checking bench for i3c_tb_unpack: three parameterisations share one stimulus bus.
// Expected bytes are queued as writes are driven and popped as the DUT offers them.
module tb_i3c_tb_unpack;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic [1:0]  wr_bytes;
  logic        wr_end;
  logic        flush;
  logic        ack;
  logic        clear;

  // index 0: LE word, 1: BE word, 2: single-byte mode
  logic        wr_ready_o [3];
  logic        tb_flush_o [3];
  logic [2:0]  pend       [3];
  logic        av_rdy     [3];
  logic [7:0]  av_dat     [3];
  logic        av_end     [3];
  logic        sovf       [3];
  logic        ovf        [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q [$];

  always #5 CLK = ~CLK;

  i3c_tb_unpack #(.ENA_WORD(1), .BIG_END(0)) u_le (
    .CLK(CLK), .RSTn(RSTn), .wr_valid(wr_valid), .wr_data(wr_data), .wr_bytes(wr_bytes),
    .wr_end(wr_end), .wr_ready(wr_ready_o[0]), .flush(flush), .tb_flush(tb_flush_o[0]),
    .pend_cnt(pend[0]), .avail_tb_ready(av_rdy[0]), .avail_tb_data(av_dat[0]),
    .avail_tb_end(av_end[0]), .avail_tb_ack(ack), .set_wr_ovf(sovf[0]), .wr_ovf(ovf[0]),
    .clear_wr_ovf(clear));

  i3c_tb_unpack #(.ENA_WORD(1), .BIG_END(1)) u_be (
    .CLK(CLK), .RSTn(RSTn), .wr_valid(wr_valid), .wr_data(wr_data), .wr_bytes(wr_bytes),
    .wr_end(wr_end), .wr_ready(wr_ready_o[1]), .flush(flush), .tb_flush(tb_flush_o[1]),
    .pend_cnt(pend[1]), .avail_tb_ready(av_rdy[1]), .avail_tb_data(av_dat[1]),
    .avail_tb_end(av_end[1]), .avail_tb_ack(ack), .set_wr_ovf(sovf[1]), .wr_ovf(ovf[1]),
    .clear_wr_ovf(clear));

  i3c_tb_unpack #(.ENA_WORD(0), .BIG_END(0)) u_byte (
    .CLK(CLK), .RSTn(RSTn), .wr_valid(wr_valid), .wr_data(wr_data), .wr_bytes(wr_bytes),
    .wr_end(wr_end), .wr_ready(wr_ready_o[2]), .flush(flush), .tb_flush(tb_flush_o[2]),
    .pend_cnt(pend[2]), .avail_tb_ready(av_rdy[2]), .avail_tb_data(av_dat[2]),
    .avail_tb_end(av_end[2]), .avail_tb_ack(ack), .set_wr_ovf(sovf[2]), .wr_ovf(ovf[2]),
    .clear_wr_ovf(clear));

  task idle_inputs;
    wr_valid = 1'b0; wr_data = '0; wr_bytes = '0; wr_end = 1'b0;
    flush = 1'b0; ack = 1'b0; clear = 1'b0;
  endtask

  task do_reset;
    @(negedge CLK);
    idle_inputs();
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    exp_q.delete();
  endtask

  task test_reset;
    idle_inputs();
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if ({av_rdy[0], av_end[0], tb_flush_o[0], sovf[0], ovf[0]} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {av_rdy[0], av_end[0], tb_flush_o[0], sovf[0], ovf[0]});
    end
    n_checks++;
    if (av_dat[0] !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", av_dat[0]); end
    n_checks++;
    if (pend[0] !== 3'd0) begin n_fail++; $display("FAIL reset_pend: got %0d expected 0", pend[0]); end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    #1;
    n_checks++;
    if (wr_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready_o[0]); end
  endtask

  task test_le_word;
    logic [8:0] e;
    do_reset();
    @(negedge CLK);
    wr_valid = 1'b1; wr_data = 32'h44332211; wr_bytes = 2'd3; wr_end = 1'b1; ack = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b1, 8'h44});
    #1;
    n_checks++;
    if (wr_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL le_accept: got %b expected 1", wr_ready_o[0]); end
    @(negedge CLK);
    wr_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (av_rdy[0] !== 1'b1) begin
        n_fail++; $display("FAIL le_ready cycle %0d: got %b expected 1", c, av_rdy[0]);
      end else begin
        n_checks++;
        if (pend[0] !== 3'(exp_q.size())) begin
          n_fail++; $display("FAIL le_pend cycle %0d: got %0d expected %0d", c, pend[0], exp_q.size());
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({av_end[0], av_dat[0]} !== e) begin
          n_fail++; $display("FAIL le_byte cycle %0d: got end=%b data=%h expected end=%b data=%h",
                             c, av_end[0], av_dat[0], e[8], e[7:0]);
        end
      end
      @(negedge CLK);
    end
    #1;
    n_checks++;
    if (av_rdy[0] !== 1'b0 || pend[0] !== 3'd0) begin
      n_fail++; $display("FAIL le_done: got ready=%b pend=%0d expected ready=0 pend=0", av_rdy[0], pend[0]);
    end
  endtask

  task test_be_back_to_back;
    logic [8:0] e;
    do_reset();
    @(negedge CLK);
    wr_valid = 1'b1; wr_data = 32'h0000BBAA; wr_bytes = 2'd1; wr_end = 1'b1; ack = 1'b1;
    exp_q.push_back({1'b0, 8'hBB});
    exp_q.push_back({1'b1, 8'hAA});
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      wr_valid = (i == 1); wr_data = 32'h000000CC; wr_bytes = 2'd0; wr_end = 1'b1;
      if (i == 1) exp_q.push_back({1'b1, 8'hCC});
      #1;
      if (i == 1) begin
        n_checks++;
        if (wr_ready_o[1] !== 1'b1) begin n_fail++; $display("FAIL be_b2b_ready: got %b expected 1", wr_ready_o[1]); end
      end
      n_checks++;
      if (av_rdy[1] !== 1'b1) begin
        n_fail++; $display("FAIL be_ready step %0d: got %b expected 1", i, av_rdy[1]);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({av_end[1], av_dat[1]} !== e) begin
          n_fail++; $display("FAIL be_byte step %0d: got end=%b data=%h expected end=%b data=%h",
                             i, av_end[1], av_dat[1], e[8], e[7:0]);
        end
      end
    end
    @(negedge CLK);
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (av_rdy[1] !== 1'b0) begin n_fail++; $display("FAIL be_done: got %b expected 0", av_rdy[1]); end
  endtask

  task test_stall_ovf;
    logic [8:0] e;
    do_reset();
    @(negedge CLK);
    wr_valid = 1'b1; wr_data = 32'h00000011; wr_bytes = 2'd0; wr_end = 1'b1; ack = 1'b0;
    exp_q.push_back({1'b1, 8'h11});
    #1;
    n_checks++;
    if (wr_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL stall_accept: got %b expected 1", wr_ready_o[0]); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      wr_valid = (k == 2) || (k == 4);
      wr_data  = 32'h00000099;
      clear    = (k == 4) || (k == 6);
      #1;
      e = exp_q[0];
      n_checks++;
      if (av_rdy[0] !== 1'b1 || {av_end[0], av_dat[0]} !== e) begin
        n_fail++; $display("FAIL stall_hold k=%0d: got ready=%b end=%b data=%h expected ready=1 end=%b data=%h",
                           k, av_rdy[0], av_end[0], av_dat[0], e[8], e[7:0]);
      end
      if (k == 2 || k == 4) begin
        n_checks++;
        if (wr_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL stall_wr_ready k=%0d: got %b expected 0", k, wr_ready_o[0]); end
      end
      if (k >= 3) begin
        n_checks++;
        if (sovf[0] !== (k == 3 || k == 5)) begin
          n_fail++; $display("FAIL stall_set_ovf k=%0d: got %b expected %b", k, sovf[0], (k == 3 || k == 5));
        end
        n_checks++;
        if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL stall_ovf k=%0d: got %b expected 1", k, ovf[0]); end
      end
    end
    @(negedge CLK);
    clear = 1'b0; ack = 1'b1;
    #1;
    n_checks++;
    if (ovf[0] !== 1'b0) begin n_fail++; $display("FAIL stall_ovf_clear: got %b expected 0", ovf[0]); end
    e = exp_q.pop_front();
    n_checks++;
    if (av_rdy[0] !== 1'b1 || {av_end[0], av_dat[0]} !== e) begin
      n_fail++; $display("FAIL stall_release: got ready=%b end=%b data=%h expected ready=1 end=%b data=%h",
                         av_rdy[0], av_end[0], av_dat[0], e[8], e[7:0]);
    end
    @(negedge CLK);
    #1;
    n_checks++;
    if (av_rdy[0] !== 1'b0 || pend[0] !== 3'd0) begin
      n_fail++; $display("FAIL stall_done: got ready=%b pend=%0d expected ready=0 pend=0", av_rdy[0], pend[0]);
    end
  endtask

  task test_flush;
    logic [8:0] e;
    do_reset();
    @(negedge CLK);
    wr_valid = 1'b1; wr_data = 32'h44332211; wr_bytes = 2'd3; wr_end = 1'b1; ack = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b1, 8'h44});
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      wr_valid = 1'b0;
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (av_rdy[0] !== 1'b1 || {av_end[0], av_dat[0]} !== e) begin
        n_fail++; $display("FAIL flush_pre_byte %0d: got ready=%b data=%h expected ready=1 data=%h",
                           c, av_rdy[0], av_dat[0], e[7:0]);
      end
    end
    @(negedge CLK);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 32'h00000055; wr_bytes = 2'd0;
    #1;
    e = exp_q[0];
    n_checks++;
    if (wr_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL flush_wr_ready: got %b expected 0", wr_ready_o[0]); end
    n_checks++;
    if (av_dat[0] !== e[7:0]) begin n_fail++; $display("FAIL flush_third_byte: got %h expected %h", av_dat[0], e[7:0]); end
    exp_q.delete();
    @(negedge CLK);
    flush = 1'b0; wr_valid = 1'b0;
    #1;
    n_checks++;
    if ({av_rdy[0], tb_flush_o[0], sovf[0]} !== 3'b010 || pend[0] !== 3'd0) begin
      n_fail++; $display("FAIL flush_after: got ready=%b tb_flush=%b set_ovf=%b pend=%0d expected ready=0 tb_flush=1 set_ovf=0 pend=0",
                         av_rdy[0], tb_flush_o[0], sovf[0], pend[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1;
      n_checks++;
      if ({av_rdy[0], tb_flush_o[0], ovf[0]} !== 3'b000) begin
        n_fail++; $display("FAIL flush_quiet %0d: got ready=%b tb_flush=%b ovf=%b expected 000",
                           c, av_rdy[0], tb_flush_o[0], ovf[0]);
      end
    end
    @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    #1;
    n_checks++;
    if (tb_flush_o[0] !== 1'b1 || av_rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got tb_flush=%b ready=%b expected tb_flush=1 ready=0", tb_flush_o[0], av_rdy[0]);
    end
    @(negedge CLK);
    #1;
    n_checks++;
    if (tb_flush_o[0] !== 1'b0) begin n_fail++; $display("FAIL flush_idle_pulse: got %b expected 0", tb_flush_o[0]); end
  endtask

  task test_word_disabled;
    logic [8:0]  e;
    logic [31:0] wd;
    logic        we;
    do_reset();
    for (int w = 0; w < 2; w++) begin
      wd = (w == 0) ? 32'h44332211 : 32'hDEADBEA5;
      we = (w == 0);
      @(negedge CLK);
      wr_valid = 1'b1; wr_data = wd; wr_bytes = 2'd3; wr_end = we; ack = 1'b1;
      exp_q.push_back({we, wd[7:0]});
      #1;
      n_checks++;
      if (wr_ready_o[2] !== 1'b1) begin n_fail++; $display("FAIL byte_accept %0d: got %b expected 1", w, wr_ready_o[2]); end
      @(negedge CLK);
      wr_valid = 1'b0;
      #1;
      n_checks++;
      if (av_rdy[2] !== 1'b1 || pend[2] !== 3'd1) begin
        n_fail++; $display("FAIL byte_ready %0d: got ready=%b pend=%0d expected ready=1 pend=1", w, av_rdy[2], pend[2]);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({av_end[2], av_dat[2]} !== e) begin
          n_fail++; $display("FAIL byte_data %0d: got end=%b data=%h expected end=%b data=%h",
                             w, av_end[2], av_dat[2], e[8], e[7:0]);
        end
      end
      @(negedge CLK);
      #1;
      n_checks++;
      if (av_rdy[2] !== 1'b0) begin n_fail++; $display("FAIL byte_done %0d: got %b expected 0", w, av_rdy[2]); end
    end
  endtask

  task test_reset_mid;
    do_reset();
    @(negedge CLK);
    wr_valid = 1'b1; wr_data = 32'h44332211; wr_bytes = 2'd3; wr_end = 1'b1; ack = 1'b0;
    @(negedge CLK);
    wr_data = 32'h00000077;
    #1;
    n_checks++;
    if (av_rdy[0] !== 1'b1 || av_dat[0] !== 8'h11) begin
      n_fail++; $display("FAIL rmid_offer: got ready=%b data=%h expected ready=1 data=11", av_rdy[0], av_dat[0]);
    end
    @(negedge CLK);
    wr_valid = 1'b0; RSTn = 1'b0;
    #1;
    n_checks++;
    if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_ovf_pre: got %b expected 1", ovf[0]); end
    @(negedge CLK);
    RSTn = 1'b1;
    #1;
    n_checks++;
    if ({av_rdy[0], av_end[0], tb_flush_o[0], sovf[0], ovf[0]} !== 5'b0 ||
        av_dat[0] !== 8'h00 || pend[0] !== 3'd0) begin
      n_fail++; $display("FAIL rmid_reset: got flags=%b data=%h pend=%0d expected flags=00000 data=00 pend=0",
                         {av_rdy[0], av_end[0], tb_flush_o[0], sovf[0], ovf[0]}, av_dat[0], pend[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      ack = 1'b1;
      #1;
      n_checks++;
      if (wr_ready_o[0] !== 1'b1 || av_rdy[0] !== 1'b0) begin
        n_fail++; $display("FAIL rmid_after %0d: got wr_ready=%b ready=%b expected wr_ready=1 ready=0",
                           c, wr_ready_o[0], av_rdy[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_le_word();
    test_be_back_to_back();
    test_stall_ovf();
    test_flush();
    test_word_disabled();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
